// File: rtl/seq_div_32_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding,
// iteration count and the two's-complement negation used for sign fix-up.
package seq_div_32_pkg;

    // One quotient bit is produced per ITER cycle.
    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ITER  = 2'd1,
        ST_FIXUP = 2'd2,
        ST_DONE  = 2'd3
    } div_state_t;

    // Two's-complement negation (invert + 1); wraps for 0x80000000.
    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

endpackage

// File: rtl/add_32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups with the group
// carries chained between groups.
module add_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = cin;

    // Each group resolves its three inner carries and its carry-out directly
    // from the group's generate/propagate terms and the incoming carry.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_cla
            localparam int B = 4 * gi;
            logic grp_g;
            logic grp_p;

            assign grp_g = g[B+3]
                         | (p[B+3] & g[B+2])
                         | (p[B+3] & p[B+2] & g[B+1])
                         | (p[B+3] & p[B+2] & p[B+1] & g[B]);
            assign grp_p = p[B+3] & p[B+2] & p[B+1] & p[B];

            assign c[B+1] = g[B] | (p[B] & c[B]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[B]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & c[B]);
            assign c[B+4] = grp_g | (grp_p & c[B]);
        end
    endgenerate

    assign sum  = p ^ c[31:0];
    assign cout = c[32];

endmodule

// File: rtl/seq_div_32_addsub.sv
// 33-bit add/subtract of a 32-bit unsigned magnitude M to/from a signed
// 33-bit partial remainder A, built on the 32-bit CLA adder.
module addsub_33 (
    input  logic [32:0] a,
    input  logic [31:0] m,
    input  logic        sub,
    output logic [32:0] res
);

    logic [31:0] m_sel;
    logic [31:0] low_sum;
    logic        c32;

    // Subtraction is A + ~M + 1; the carry-in supplies the +1.
    assign m_sel = sub ? ~m : m;

    add_32 u_add_32 (
        .a    (a[31:0]),
        .b    (m_sel),
        .cin  (sub),
        .sum  (low_sum),
        .cout (c32)
    );

    // M is zero-extended, so its bit 32 is 0, or 1 once inverted.
    assign res = {a[32] ^ sub ^ c32, low_sum};

endmodule

// File: rtl/seq_div_32.sv
// Multi-cycle signed 32-bit non-restoring divider with start/busy/done
// handshake. Quotient truncates toward zero; remainder takes the
// dividend's sign.
module seq_div_32
    import seq_div_32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_ITERS - 1);

    div_state_t       state_reg;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             qneg_reg;
    logic             rneg_reg;
    logic             dbz_pending_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] quotient_reg;
    logic [WIDTH-1:0] remainder_reg;
    logic             dbz_reg;

    logic [WIDTH:0]   a_shift;
    logic [WIDTH:0]   as_a;
    logic             as_sub;
    logic [WIDTH:0]   as_res;
    logic [WIDTH-1:0] a_fix;

    // The single add/subtract engine serves both the per-bit step in ITER
    // (on the shifted A, direction chosen by the old A sign) and the final
    // remainder restore in FIXUP (always an add).
    always_comb begin
        a_shift = {a_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        as_a    = a_reg;
        as_sub  = 1'b0;
        if (state_reg == ST_ITER) begin
            as_a   = a_shift;
            as_sub = ~a_reg[WIDTH];
        end
        a_fix = a_reg[WIDTH] ? as_res[WIDTH-1:0] : a_reg[WIDTH-1:0];
    end

    addsub_33 u_addsub (
        .a   (as_a),
        .m   (m_reg),
        .sub (as_sub),
        .res (as_res)
    );

    // Divider FSM together with the A/Q/M datapath registers and outputs.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_reg       <= ST_IDLE;
            a_reg           <= '0;
            q_reg           <= '0;
            m_reg           <= '0;
            cnt_reg         <= '0;
            qneg_reg        <= 1'b0;
            rneg_reg        <= 1'b0;
            dbz_pending_reg <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            dbz_reg         <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        busy_reg <= 1'b1;
                        if (divisor == '0) begin
                            // Divide-by-zero spends one cycle in FIXUP so
                            // done lands one edge after acceptance; Q parks
                            // the raw dividend for the remainder output.
                            dbz_pending_reg <= 1'b1;
                            q_reg           <= dividend;
                            state_reg       <= ST_FIXUP;
                        end else begin
                            dbz_pending_reg <= 1'b0;
                            q_reg     <= dividend[WIDTH-1] ? neg32(dividend) : dividend;
                            m_reg     <= divisor[WIDTH-1] ? neg32(divisor) : divisor;
                            a_reg     <= '0;
                            qneg_reg  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            rneg_reg  <= dividend[WIDTH-1];
                            cnt_reg   <= '0;
                            state_reg <= ST_ITER;
                        end
                    end
                end

                ST_ITER: begin
                    a_reg   <= as_res;
                    q_reg   <= {q_reg[WIDTH-2:0], ~as_res[WIDTH]};
                    cnt_reg <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        state_reg <= ST_FIXUP;
                    end
                end

                ST_FIXUP: begin
                    if (dbz_pending_reg) begin
                        quotient_reg  <= '1;
                        remainder_reg <= q_reg;
                        dbz_reg       <= 1'b1;
                    end else begin
                        quotient_reg  <= qneg_reg ? neg32(q_reg) : q_reg;
                        remainder_reg <= rneg_reg ? neg32(a_fix) : a_fix;
                        dbz_reg       <= 1'b0;
                    end
                    done_reg  <= 1'b1;
                    state_reg <= ST_DONE;
                end

                ST_DONE: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_div_32.sv
// Scoreboard bench for seq_div_32: the stimulus process pushes expected
// results computed with plain signed arithmetic; a monitor pops on done.
module tb_seq_div_32;

    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    seq_div_32 dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
        int          due;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_bad = 0;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: signed integer division in 64-bit arithmetic, truncated.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int due);
        exp_t   e;
        longint sa;
        longint sd;
        longint qq;
        longint rr;
        sa = longint'($signed(a));
        sd = longint'($signed(b));
        e.a = a;
        e.b = b;
        e.due = due;
        if (sd == 0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            qq    = sa / sd;
            rr    = sa % sd;
            e.q   = qq[31:0];
            e.r   = rr[31:0];
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no pending op", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn %h / %h -> q=%h r=%h dbz=%0d cycle=%0d", e.a, e.b, quotient, remainder, div_by_zero, cyc);
                check32("quotient", quotient, e.q);
                check32("remainder", remainder, e.r);
                check32("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
                check32("done_latency", cyc, e.due);
                check32("busy_with_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (busy !== 1'b0 || done !== 1'b0) begin
            @(negedge clk);
            t++;
            if (t > 200) begin
                n_vec++;
                n_bad++;
                $display("FAIL idle_timeout: got busy=%0d, expected 0 within 200 cycles", busy);
                return;
            end
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        wait_idle();
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b, cyc + ((b == 32'd0) ? 2 : 34)));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 || busy !== 1'b0) begin
            @(negedge clk);
            t++;
            if (t > 300) begin
                n_vec++;
                n_bad++;
                $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
                sb.delete();
                return;
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int ndone;
        logic [31:0] ra;
        logic [31:0] rb;

        clr      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_done", {31'd0, done}, 32'd0);
        check32("rst_quotient", quotient, 32'd0);
        check32("rst_remainder", remainder, 32'd0);
        check32("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        clr = 1'b0;
        @(negedge clk);

        // Directed cases: signs, overflow, largest positive, divide-by-zero.
        issue(32'd100, 32'd7);
        issue(32'hFFFF_FF9C, 32'd7);
        issue(32'd100, 32'hFFFF_FFF9);
        issue(32'h8000_0000, 32'hFFFF_FFFF);
        issue(32'h7FFF_FFFF, 32'd1);
        issue(32'd5, 32'd0);
        issue(32'd9, 32'd3);
        drain();

        // Start pulsed mid-operation must be ignored.
        issue(32'd100, 32'd7);
        repeat (9) @(negedge clk);
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // Start held high: the second op is accepted only once back in IDLE.
        wait_idle();
        c        = cyc;
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        sb.push_back(model(32'd9, 32'd3, c + 34));
        sb.push_back(model(32'd9, 32'd3, c + 69));
        repeat (36) @(negedge clk);
        start = 1'b0;
        drain();

        // clr mid-operation abandons it and zeroes the outputs.
        wait_idle();
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check32("clr_busy", {31'd0, busy}, 32'd0);
        check32("clr_done", {31'd0, done}, 32'd0);
        check32("clr_quotient", quotient, 32'd0);
        check32("clr_remainder", remainder, 32'd0);
        check32("clr_dbz", {31'd0, div_by_zero}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check32("no_done_after_clr", ndone, 32'd0);
        issue(32'd1000, 32'd3);
        drain();

        // Randomised operands across several magnitude/sign regimes.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0: begin ra = $urandom; rb = $urandom; end
                1: begin ra = $urandom; rb = $urandom_range(0, 40) - 20; end
                2: begin ra = $urandom; rb = 32'd0; end
                3: begin ra = 32'h8000_0000; rb = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom; end
                4: begin ra = $urandom_range(0, 1000); rb = $urandom; end
                default: begin ra = $urandom_range(0, 2000) - 1000; rb = $urandom_range(1, 50); end
            endcase
            issue(ra, rb);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
